// File: rtl/kb_pkg.sv
// -----------------------------------------------------------------------------
// kb_pkg
// Shared definitions for the 2-bit keypad link: digit width, transmitter state
// encoding and the default setup/gap timing used by both the keypad-side
// transmitter and the alarm-side receiver.
// -----------------------------------------------------------------------------
package kb_pkg;

    // Bits per keypad digit; fixed by the physical link.
    localparam int SYM_W = 2;

    // Default link timing, shared with the receiver so both ends agree.
    localparam int DEF_SETUP_CYCLES = 1;
    localparam int DEF_GAP_CYCLES   = 5;

    // Transmitter state encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } kb_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/kb_code_tx.sv
// -----------------------------------------------------------------------------
// kb_code_tx
// Keypad-side transmitter. Accepts a complete access code of SYMBOLS 2-bit
// digits and sends it digit by digit on kb_in, qualifying each digit with a
// one-cycle kb_recv strobe. Each digit is presented for SETUP_CYCLES before
// its strobe and held for GAP_CYCLES after it.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   key_data   in   code to send; digit 0 sits in the MSBs
//   key_start  in   one-cycle request, honoured only when idle
//   abort      in   synchronous cancel, overrides everything but reset
//   kb_in      out  current digit
//   kb_recv    out  one-cycle strobe marking kb_in valid
//   busy       out  high while a code is being sent (through the DONE cycle)
//   done       out  one-cycle pulse after the last digit's gap
// -----------------------------------------------------------------------------
module kb_code_tx
    import kb_pkg::*;
#(
    parameter int SYMBOLS      = 4,
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [SYMBOLS*SYM_W-1:0] key_data,
    input  logic                     key_start,
    input  logic                     abort,
    output logic [SYM_W-1:0]         kb_in,
    output logic                     kb_recv,
    output logic                     busy,
    output logic                     done
);

    localparam int CODE_W = SYMBOLS * SYM_W;
    // The phase counter counts down to zero, so it only has to hold max-1.
    localparam int PH_MAX = max_int(SETUP_CYCLES, GAP_CYCLES) - 1;
    localparam int PH_W   = (PH_MAX < 1) ? 1 : $clog2(PH_MAX + 1);
    localparam int IDX_W  = (SYMBOLS < 2) ? 1 : $clog2(SYMBOLS);

    localparam logic [PH_W-1:0]  SETUP_LOAD = PH_W'(SETUP_CYCLES - 1);
    localparam logic [PH_W-1:0]  GAP_LOAD   = PH_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(SYMBOLS - 1);

    kb_state_t         state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [CODE_W-1:0] shreg_q, shreg_d;

    logic [SYM_W-1:0]  kb_in_d;
    logic              kb_recv_d;
    logic              busy_d;
    logic              done_d;

    // Next-state, counters, shift register and the next values of the
    // registered outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (key_start) begin
                        state_d = ST_SETUP;
                        shreg_d = key_data;
                        idx_d   = '0;
                        phase_d = SETUP_LOAD;
                    end
                end
                ST_SETUP: begin
                    if (phase_q == '0) state_d = ST_STROBE;
                    else               phase_d = phase_q - 1'b1;
                end
                ST_STROBE: begin
                    state_d = ST_GAP;
                    phase_d = GAP_LOAD;
                end
                ST_GAP: begin
                    if (phase_q != '0) begin
                        phase_d = phase_q - 1'b1;
                    end else if (idx_q != LAST_IDX) begin
                        // Next digit moves up into the MSBs that drive kb_in.
                        state_d = ST_SETUP;
                        phase_d = SETUP_LOAD;
                        idx_d   = idx_q + 1'b1;
                        shreg_d = shreg_q << SYM_W;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
                ST_FINISH: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they can be registered
        // and still line up with the state they belong to.
        kb_in_d   = '0;
        kb_recv_d = 1'b0;
        done_d    = 1'b0;
        busy_d    = (state_d != ST_IDLE);
        unique case (state_d)
            ST_SETUP, ST_GAP: kb_in_d = shreg_d[CODE_W-1 -: SYM_W];
            ST_STROBE: begin
                kb_in_d   = shreg_d[CODE_W-1 -: SYM_W];
                kb_recv_d = 1'b1;
            end
            ST_FINISH: done_d = 1'b1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            kb_in   <= '0;
            kb_recv <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            kb_in   <= kb_in_d;
            kb_recv <= kb_recv_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_kb_code_tx.sv
// -----------------------------------------------------------------------------
// tb_kb_code_tx
// Self-checking bench for kb_code_tx. Two instances run side by side: one with
// default parameters and one with SETUP_CYCLES=3, GAP_CYCLES=1, SYMBOLS=2.
// A reference model tracks, per instance, when a code was accepted and derives
// every output from the cycle offset into the transfer and the digit period.
// -----------------------------------------------------------------------------
module tb_kb_code_tx;
    import kb_pkg::*;

    localparam int BN = 4, BS = 1, BG = 5;   // default instance
    localparam int SN = 2, SS = 3, SG = 1;   // small instance

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] b_data;
    logic       b_start, b_abort;
    logic [1:0] b_in;
    logic       b_recv, b_busy, b_done;
    logic [3:0] s_data;
    logic       s_start, s_abort;
    logic [1:0] s_in;
    logic       s_recv, s_busy, s_done;

    always #5 clk = ~clk;

    kb_code_tx #(.SYMBOLS(BN), .SETUP_CYCLES(BS), .GAP_CYCLES(BG)) u_big (
        .clk(clk), .reset_n(reset_n), .key_data(b_data), .key_start(b_start),
        .abort(b_abort), .kb_in(b_in), .kb_recv(b_recv), .busy(b_busy), .done(b_done)
    );

    kb_code_tx #(.SYMBOLS(SN), .SETUP_CYCLES(SS), .GAP_CYCLES(SG)) u_small (
        .clk(clk), .reset_n(reset_n), .key_data(s_data), .key_start(s_start),
        .abort(s_abort), .kb_in(s_in), .kb_recv(s_recv), .busy(s_busy), .done(s_done)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model state per instance (0 = default, 1 = small).
    bit         act [2];
    int         c0  [2];
    logic [7:0] mdat[2];
    bit         prev_recv[2];

    // Observation logs for the directed scenarios.
    logic [1:0] strobe_log[$];
    int         done_cnt;

    function automatic int n_of(input int i); return (i == 0) ? BN : SN; endfunction
    function automatic int s_of(input int i); return (i == 0) ? BS : SS; endfunction
    function automatic int g_of(input int i); return (i == 0) ? BG : SG; endfunction
    function automatic int p_of(input int i); return s_of(i) + 1 + g_of(i); endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Expected outputs n cycles after acceptance (n<1 means not transferring).
    function automatic void expect_out(input int i, input int n, input logic [7:0] d,
                                       output logic [1:0] ein, output logic erecv,
                                       output logic ebusy, output logic edone);
        int p, k, r;
        p = p_of(i);
        ein = 2'd0; erecv = 1'b0; ebusy = 1'b0; edone = 1'b0;
        if (n >= 1 && n <= n_of(i) * p) begin
            k     = (n - 1) / p;
            r     = (n - 1) % p;
            ebusy = 1'b1;
            ein   = 2'((d >> (2 * (n_of(i) - 1 - k))) & 8'd3);
            erecv = (r == s_of(i));
        end else if (n == n_of(i) * p + 1) begin
            ebusy = 1'b1;
            edone = 1'b1;
        end
    endfunction

    // Advance the model across the edge that ends cycle 'cyc'.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            logic st, ab;
            logic [7:0] d;
            bit idle;
            st = (i == 0) ? b_start : s_start;
            ab = (i == 0) ? b_abort : s_abort;
            d  = (i == 0) ? b_data  : {4'd0, s_data};
            idle = !act[i] || (cyc - c0[i] >= n_of(i) * p_of(i) + 2);
            if (!reset_n)             act[i] = 1'b0;
            else if (ab)              act[i] = 1'b0;
            else if (idle && st) begin
                act[i] = 1'b1; c0[i] = cyc; mdat[i] = d;
            end else if (idle)        act[i] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            logic [1:0] ein, oin;
            logic erecv, ebusy, edone, orecv, obusy, odone;
            expect_out(i, act[i] ? (cyc - c0[i]) : -1, mdat[i], ein, erecv, ebusy, edone);
            oin   = (i == 0) ? b_in   : s_in;
            orecv = (i == 0) ? b_recv : s_recv;
            obusy = (i == 0) ? b_busy : s_busy;
            odone = (i == 0) ? b_done : s_done;
            check((i == 0) ? "big.kb_in"   : "small.kb_in",   {6'd0, oin},   {6'd0, ein});
            check((i == 0) ? "big.kb_recv" : "small.kb_recv", {7'd0, orecv}, {7'd0, erecv});
            check((i == 0) ? "big.busy"    : "small.busy",    {7'd0, obusy}, {7'd0, ebusy});
            check((i == 0) ? "big.done"    : "small.done",    {7'd0, odone}, {7'd0, edone});
            check((i == 0) ? "big.recv_adjacent" : "small.recv_adjacent",
                  {7'd0, prev_recv[i] & orecv}, 8'd0);
            prev_recv[i] = orecv;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check_all();
        if (b_recv) strobe_log.push_back(b_in);
        if (s_recv) strobe_log.push_back(s_in);
        if (b_done || s_done) done_cnt++;
    endtask

    task automatic check_log(input string tag, input logic [7:0] exp_code, input int nd);
        check({tag, ".strobe_count"}, 8'(strobe_log.size()), 8'(nd));
        for (int k = 0; k < nd && k < strobe_log.size(); k++)
            check({tag, ".digit"}, {6'd0, strobe_log[k]},
                  (exp_code >> (2 * (nd - 1 - k))) & 8'd3);
        check({tag, ".done_count"}, 8'(done_cnt), 8'd1);
        strobe_log.delete();
        done_cnt = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        b_data = '0; b_start = 1'b0; b_abort = 1'b0;
        s_data = '0; s_start = 1'b0; s_abort = 1'b0;
        done_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all();                       // reset values
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;

        // Basic transfer with a re-START at cycle 5 and data change at 6.
        b_data = 8'b00_01_10_11; b_start = 1'b1;
        step();                            // now in cycle 1
        b_start = 1'b0;
        repeat (4) step();                 // cycle 5
        b_start = 1'b1;
        step();                            // cycle 6
        b_start = 1'b0; b_data = 8'hFF;
        repeat (24) step();                // cycle 30 (IDLE)
        check("t1.busy_at_30", {7'd0, b_busy}, 8'd0);
        check_log("t1", 8'b00_01_10_11, 4);

        // Back-to-back START in the IDLE cycle right after DONE.
        b_data = 8'(($urandom & 32'hFF)); b_start = 1'b1;
        step();                            // cycle 1 of new transfer
        b_start = 1'b0;
        step();                            // cycle 2: first strobe
        check("b2b.first_strobe", {7'd0, b_recv}, 8'd1);
        repeat (8) step();                 // cycle 10
        b_abort = 1'b1;
        step();                            // cycle 11: all zero
        b_abort = 1'b0;
        check("abort.busy", {7'd0, b_busy}, 8'd0);
        strobe_log.delete(); done_cnt = 0;
        step();                            // cycle 12
        b_data = 8'b11_10_01_00; b_start = 1'b1;
        step();
        b_start = 1'b0;
        repeat (32) step();
        check_log("after_abort", 8'b11_10_01_00, 4);

        // Reset in the middle of the strobe for digit 2.
        b_data = 8'b00_01_10_11; b_start = 1'b1;
        step();                            // cycle 1
        b_start = 1'b0;
        repeat (15) step();                // cycle 16
        check("rst.pre_recv", {7'd0, b_recv}, 8'd1);
        check("rst.pre_in",   {6'd0, b_in},   8'd2);
        #2;
        reset_n = 1'b0;
        #1;
        act[0] = 1'b0; act[1] = 1'b0;
        check_all();                       // outputs drop without a clock edge
        step();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) step();
        check("rst.busy_after", {7'd0, b_busy}, 8'd0);
        strobe_log.delete(); done_cnt = 0;

        // Small instance: SETUP=3, GAP=1, two digits.
        s_data = 4'b10_01; s_start = 1'b1;
        step();
        s_start = 1'b0;
        repeat (12) step();
        check_log("small", 8'b0000_10_01, 2);

        // Randomized traffic on both instances.
        for (int t = 0; t < 400; t++) begin
            b_data  = 8'($urandom);
            s_data  = 4'($urandom);
            b_start = ($urandom_range(0, 3) == 0);
            s_start = ($urandom_range(0, 3) == 0);
            b_abort = ($urandom_range(0, 47) == 0);
            s_abort = ($urandom_range(0, 47) == 0);
            step();
        end
        b_start = 1'b0; s_start = 1'b0; b_abort = 1'b0; s_abort = 1'b0;
        repeat (35) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/kb_code_tx.md
# kb_code_tx

Keypad-side transmitter for the alarm's 2-bit keypad link. It takes a complete access code (SYMBOLS × 2-bit digits), then drives it symbol by symbol onto KB_IN, qualifying each symbol with a one-cycle KB_RECV strobe. It is the sending end of the interface the alarm main module consumes. It sits in the keypad/panel subsystem and also serves as the stimulus source in system-level benches.

## Interface
- SYMBOLS, 4: digits per code.
- SYM_W, 2: bits per digit; fixed by the link, not overridden.
- SETUP_CYCLES, 1: cycles KB_IN is stable before the strobe; legal range ≥1.
- GAP_CYCLES, 5: cycles after the strobe before the next digit is presented; legal range ≥1.

- CLK  in  1  system clock; all state changes on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- KEY_DATA  in  SYMBOLS*SYM_W  code to send; digit 0 = MSBs [7:6].
- KEY_START  in  1  one-cycle request; sampled only in IDLE.
- ABORT  in  1  synchronous cancel; wins over everything except reset.
- KB_IN  out  2  current digit.
- KB_RECV  out  1  one-cycle strobe: KB_IN is valid.
- BUSY  out  1  high from the cycle after an accepted START until return to IDLE.
- DONE  out  1  one-cycle pulse after the last digit's gap.

## Operation
- States: IDLE, SETUP, STROBE, GAP, FINISH.
- IDLE, START=1, ABORT=0: latch KEY_DATA into a shift register, clear the digit index, go to SETUP.
- SETUP: KB_IN = current digit, KB_RECV=0. Stay SETUP_CYCLES cycles, then go to STROBE.
- STROBE: exactly 1 cycle. KB_RECV=1, KB_IN held. Then go to GAP.
- GAP: KB_IN held, KB_RECV=0 for GAP_CYCLES cycles.
  - If index < SYMBOLS-1: shift, increment index, go to SETUP.
  - Otherwise go to FINISH.
- FINISH: DONE=1 for 1 cycle, KB_IN→0, then go to IDLE.
- KEY_START outside IDLE is ignored; it is not queued.
- Changes to KEY_DATA after acceptance have no effect.
- ABORT=1 in any state:
  - next state is IDLE;
  - KB_IN, KB_RECV, BUSY and DONE are all 0 from the next cycle;
  - no DONE is issued.
- ABORT and KEY_START together in IDLE: ABORT wins and the request is dropped.
- The phase counter is wide enough for max(SETUP_CYCLES, GAP_CYCLES) and reloads on each state entry.
- The index counter is $clog2(SYMBOLS) bits and never wraps within a code.

## Timing
- All outputs are registered.
- Reset values: KB_IN=0, KB_RECV=0, BUSY=0, DONE=0, state IDLE.
- Reset mid-transfer discards the code immediately (asynchronous); there is no partial DONE.
- Cycle numbering: START sampled at edge 0.
  - SETUP occupies cycles 1..SETUP_CYCLES.
  - Digit k strobes at cycle 1+SETUP_CYCLES+k·P, where P = SETUP_CYCLES+1+GAP_CYCLES.
  - DONE is at cycle 1+SYMBOLS·P.
  - IDLE is at cycle 2+SYMBOLS·P, and a new START is accepted there.
- With default parameters: P=7, strobes at cycles 2, 9, 16, 23, DONE at 29, BUSY high for cycles 1–29.
- KB_RECV is never high for two consecutive cycles.
- KB_IN never changes in the cycle before a strobe, during the strobe, or in the cycle after it.

## Structure
- Shared package kb_pkg holds:
  - SYM_W;
  - state encoding localparams (ST_IDLE, ST_SETUP, ST_STROBE, ST_GAP, ST_FINISH);
  - default SETUP/GAP constants, shared with the alarm-side receiver.
- No sub-module: one FSM plus a phase counter, an index counter and a shift register in a single module.

## Test plan
- Default parameters, KEY_DATA=8'b00_01_10_11, START at cycle 0 → KB_RECV at cycles 2, 9, 16, 23 with KB_IN = 0, 1, 2, 3; DONE at 29; BUSY high for 1–29.
- START pulsed again at cycle 5, with KEY_DATA changed to 8'hFF at cycle 6 → transfer unaffected, same 0, 1, 2, 3 sequence, exactly one DONE.
- ABORT at cycle 10, during the GAP after digit 1 → from cycle 11 all outputs 0, no further strobes, no DONE; START at cycle 12 is accepted and sends a full code.
- RESET_N low at cycle 16, mid-STROBE → KB_RECV and KB_IN drop asynchronously; after release the block is IDLE and BUSY=0.
- SETUP_CYCLES=3, GAP_CYCLES=1, SYMBOLS=2, KEY_DATA=4'b10_01 → P=5; strobes at 4 and 9 with KB_IN = 2, 1; DONE at 11.
- Back-to-back: START again in the IDLE cycle right after DONE (cycle 30) → accepted; first strobe at 32; KB_RECV never asserted in adjacent cycles.
